// File: rtl/wt_cache_mem_arbiter.sv
// Shares the write-through memory port between icache (src 0) and dcache (src 1),
// locks each grant until acked, alternates round-robin, and routes returns back.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   stall_i             blocks new grants from IDLE
//   icache_*            icache request (req/addr/tid) and ack
//   dcache_*            dcache request (req/addr/we/wdata/tid) and ack
//   mem_*               muxed downstream request, mem_tid_o = {src, tid}
//   mem_rtrn_*          downstream return, routed by tid MSB
//   icache/dcache_rtrn_vld_o, rtrn_tid_o, rtrn_data_o   routed return
//   busy_o              grant held or any transaction in flight
module wt_cache_mem_arbiter #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic                 icache_req_i,
  output logic                 icache_ack_o,
  input  logic [AddrWidth-1:0] icache_addr_i,
  input  logic [TidWidth-1:0]  icache_tid_i,
  input  logic                 dcache_req_i,
  output logic                 dcache_ack_o,
  input  logic [AddrWidth-1:0] dcache_addr_i,
  input  logic                 dcache_we_i,
  input  logic [DataWidth-1:0] dcache_wdata_i,
  input  logic [TidWidth-1:0]  dcache_tid_i,
  output logic                 mem_req_o,
  input  logic                 mem_ack_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [TidWidth:0]    mem_tid_o,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth:0]    mem_rtrn_tid_i,
  input  logic [DataWidth-1:0] mem_rtrn_data_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic [DataWidth-1:0] rtrn_data_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } state_e;

  state_e state_q, state_d;
  logic                rr_q;
  logic [CntWidth-1:0] icnt_q, dcnt_q;
  logic                i_elig, d_elig;
  logic                sel;
  logic                xfer;
  logic                i_ret, d_ret;
  logic                i_inc, i_dec;
  logic                d_inc, d_dec;

  assign i_elig = icache_req_i & (icnt_q < CntMax);
  assign d_elig = dcache_req_i & (dcnt_q < CntMax);

  always_comb begin
    state_d   = state_q;
    sel       = 1'b0;
    mem_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stall_i && (i_elig || d_elig)) begin
          mem_req_o = 1'b1;
          // rr_q=1 means the dcache is preferred on a tie
          sel = d_elig & (~i_elig | rr_q);
          if (!mem_ack_i) state_d = sel ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) state_d = IDLE;
      end
      LOCK_D: begin
        mem_req_o = 1'b1;
        sel       = 1'b1;
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer         = mem_req_o & mem_ack_i;
  assign icache_ack_o = xfer & ~sel;
  assign dcache_ack_o = xfer & sel;

  assign mem_addr_o  = sel ? dcache_addr_i : icache_addr_i;
  assign mem_we_o    = sel & dcache_we_i;
  assign mem_wdata_o = sel ? dcache_wdata_i : '0;
  assign mem_tid_o   = {sel, sel ? dcache_tid_i : icache_tid_i};

  assign i_ret = mem_rtrn_vld_i & ~mem_rtrn_tid_i[TidWidth];
  assign d_ret = mem_rtrn_vld_i & mem_rtrn_tid_i[TidWidth];

  assign icache_rtrn_vld_o = i_ret;
  assign dcache_rtrn_vld_o = d_ret;
  assign rtrn_tid_o        = mem_rtrn_tid_i[TidWidth-1:0];
  assign rtrn_data_o       = mem_rtrn_data_i;

  // A return against an empty counter is ignored so the count cannot wrap
  assign i_inc = icache_ack_o;
  assign i_dec = i_ret & (icnt_q != '0);
  assign d_inc = dcache_ack_o;
  assign d_dec = d_ret & (dcnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) rr_q <= ~sel;
      if (i_inc && !i_dec) icnt_q <= icnt_q + 1'b1;
      else if (i_dec && !i_inc) icnt_q <= icnt_q - 1'b1;
      if (d_inc && !d_dec) dcnt_q <= dcnt_q + 1'b1;
      else if (d_dec && !d_inc) dcnt_q <= dcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(i_ret && icnt_q == '0))
        else $error("icache return with no transaction in flight");
      assert (!(d_ret && dcnt_q == '0))
        else $error("dcache return with no transaction in flight");
    end
  end

  assign busy_o = (state_q != IDLE) | (icnt_q != '0) | (dcnt_q != '0);

endmodule

// File: tb/tb_wt_cache_mem_arbiter.sv
// Randomized bench for wt_cache_mem_arbiter against a transaction-level model.
// Requesters hold fields until acked; in-flight transactions live in queues.
module tb_wt_cache_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int MO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          stall_i;
  logic          icache_req_i;
  logic          icache_ack_o;
  logic [AW-1:0] icache_addr_i;
  logic [TW-1:0] icache_tid_i;
  logic          dcache_req_i;
  logic          dcache_ack_o;
  logic [AW-1:0] dcache_addr_i;
  logic          dcache_we_i;
  logic [DW-1:0] dcache_wdata_i;
  logic [TW-1:0] dcache_tid_i;
  logic          mem_req_o;
  logic          mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_wdata_o;
  logic [TW:0]   mem_tid_o;
  logic          mem_rtrn_vld_i;
  logic [TW:0]   mem_rtrn_tid_i;
  logic [DW-1:0] mem_rtrn_data_i;
  logic          icache_rtrn_vld_o;
  logic          dcache_rtrn_vld_o;
  logic [TW-1:0] rtrn_tid_o;
  logic [DW-1:0] rtrn_data_o;
  logic          busy_o;

  wt_cache_mem_arbiter #(
    .AddrWidth(AW), .DataWidth(DW),
    .TidWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .icache_req_i(icache_req_i), .icache_ack_o(icache_ack_o),
    .icache_addr_i(icache_addr_i), .icache_tid_i(icache_tid_i),
    .dcache_req_i(dcache_req_i), .dcache_ack_o(dcache_ack_o),
    .dcache_addr_i(dcache_addr_i), .dcache_we_i(dcache_we_i),
    .dcache_wdata_i(dcache_wdata_i), .dcache_tid_i(dcache_tid_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_tid_o(mem_tid_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_tid_i(mem_rtrn_tid_i),
    .mem_rtrn_data_i(mem_rtrn_data_i),
    .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model: pending requests, owner of an unacked grant, tie preference,
  // and the tids in flight per source
  bit            i_pend, d_pend;
  int            held;
  int            pref;
  logic [TW-1:0] iq[$];
  logic [TW-1:0] dq[$];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    i_pend = 0;
    d_pend = 0;
    held   = -1;
    pref   = 0;
    iq.delete();
    dq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni         = 1'b0;
    icache_req_i   = 1'b0;
    dcache_req_i   = 1'b0;
    stall_i        = 1'b0;
    mem_ack_i      = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    mem_rtrn_tid_i = '0;
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_iack", icache_ack_o, 0);
    chk("rst_dack", dcache_ack_o, 0);
    chk("rst_irtrn", icache_rtrn_vld_o, 0);
    chk("rst_drtrn", dcache_rtrn_vld_o, 0);
  endtask

  task automatic cycle(input int p_new, input int p_ack,
                       input int p_ret, input int p_stall);
    int  ret_src;
    int  s;
    bit  ie, de, ereq;
    int  esel;
    bit  ebusy;
    @(negedge clk_i);
    if (!i_pend && $urandom_range(99) < p_new) begin
      i_pend        = 1;
      icache_addr_i = {$urandom, $urandom};
      icache_tid_i  = TW'($urandom);
    end
    if (!d_pend && $urandom_range(99) < p_new) begin
      d_pend         = 1;
      dcache_addr_i  = {$urandom, $urandom};
      dcache_we_i    = 1'($urandom);
      dcache_wdata_i = {$urandom, $urandom};
      dcache_tid_i   = TW'($urandom);
    end
    icache_req_i    = i_pend;
    dcache_req_i    = d_pend;
    stall_i         = ($urandom_range(99) < p_stall);
    mem_ack_i       = ($urandom_range(99) < p_ack);
    mem_rtrn_data_i = {$urandom, $urandom};
    ret_src = -1;
    if ($urandom_range(99) < p_ret) begin
      s = int'($urandom_range(1));
      if (s == 0 && iq.size() == 0) s = 1;
      if (s == 1 && dq.size() == 0 && iq.size() != 0) s = 0;
      if (s == 0 && iq.size() != 0) ret_src = 0;
      if (s == 1 && dq.size() != 0) ret_src = 1;
    end
    if (ret_src == 0) begin
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = {1'b0, iq[0]};
    end else if (ret_src == 1) begin
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = {1'b1, dq[0]};
    end else begin
      mem_rtrn_vld_i = 1'b0;
      mem_rtrn_tid_i = (TW+1)'($urandom);
    end
    #1;
    ie    = i_pend && iq.size() < MO;
    de    = d_pend && dq.size() < MO;
    ebusy = (held >= 0) || iq.size() != 0 || dq.size() != 0;
    ereq  = 0;
    esel  = 0;
    if (held >= 0) begin
      ereq = 1;
      esel = held;
    end else if (!stall_i && (ie || de)) begin
      ereq = 1;
      esel = (ie && de) ? pref : (de ? 1 : 0);
    end
    chk("mem_req", mem_req_o, ereq);
    if (ereq) begin
      if (esel == 1) begin
        chk("mem_tid", mem_tid_o, {1'b1, dcache_tid_i});
        chk("mem_addr", mem_addr_o, dcache_addr_i);
        chk("mem_we", mem_we_o, dcache_we_i);
        chk("mem_wdata", mem_wdata_o, dcache_wdata_i);
      end else begin
        chk("mem_tid", mem_tid_o, {1'b0, icache_tid_i});
        chk("mem_addr", mem_addr_o, icache_addr_i);
        chk("mem_we", mem_we_o, 0);
        chk("mem_wdata", mem_wdata_o, 0);
      end
    end
    chk("icache_ack", icache_ack_o, ereq && mem_ack_i && esel == 0);
    chk("dcache_ack", dcache_ack_o, ereq && mem_ack_i && esel == 1);
    chk("busy", busy_o, ebusy);
    chk("irtrn_vld", icache_rtrn_vld_o,
        mem_rtrn_vld_i && !mem_rtrn_tid_i[TW]);
    chk("drtrn_vld", dcache_rtrn_vld_o,
        mem_rtrn_vld_i && mem_rtrn_tid_i[TW]);
    chk("rtrn_tid", rtrn_tid_o, mem_rtrn_tid_i[TW-1:0]);
    chk("rtrn_data", rtrn_data_o, mem_rtrn_data_i);
    if (ret_src == 0) void'(iq.pop_front());
    if (ret_src == 1) void'(dq.pop_front());
    if (ereq && mem_ack_i) begin
      if (esel == 1) begin
        dq.push_back(dcache_tid_i);
        d_pend = 0;
      end else begin
        iq.push_back(icache_tid_i);
        i_pend = 0;
      end
      pref = 1 - esel;
      held = -1;
    end else if (ereq) begin
      held = esel;
    end
  endtask

  initial begin
    rst_ni          = 1'b0;
    stall_i         = 1'b0;
    icache_req_i    = 1'b0;
    dcache_req_i    = 1'b0;
    icache_addr_i   = '0;
    icache_tid_i    = '0;
    dcache_addr_i   = '0;
    dcache_we_i     = 1'b0;
    dcache_wdata_i  = '0;
    dcache_tid_i    = '0;
    mem_ack_i       = 1'b0;
    mem_rtrn_vld_i  = 1'b0;
    mem_rtrn_tid_i  = '0;
    mem_rtrn_data_i = '0;
    model_clear();
    do_reset();

    // saturated: both requesting, ack always high
    repeat (40) cycle(100, 100, 60, 0);
    // slow acks, rare returns: long locks and outstanding limit
    repeat (200) cycle(70, 40, 10, 20);
    // mixed traffic
    repeat (200) cycle(50, 60, 50, 30);

    // reset while a grant is locked
    begin
      int n = 0;
      while (held < 0 && n < 30) begin
        cycle(100, 0, 0, 0);
        n++;
      end
      chk("lock_reached", held >= 0, 1);
    end
    do_reset();

    repeat (400) cycle($urandom_range(20, 100), $urandom_range(0, 100),
                       $urandom_range(0, 100), $urandom_range(0, 50));

    // drain everything and confirm busy falls
    begin
      int n = 0;
      while ((i_pend || d_pend || held >= 0 ||
              iq.size() != 0 || dq.size() != 0) && n < 200) begin
        cycle(0, 100, 100, 0);
        n++;
      end
      chk("drained", n < 200, 1);
      cycle(0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
